regfile_wr_arbiter: RTL

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

---
 rtl/regfile_wr_arbiter_if.sv | 32 +++
 rtl/regfile_wr_arbiter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter_if.sv
// Write-request bus between requesters and the register-file write arbiter.
//   req_valid/req_addr/req_data : per-requester write requests (requester i at slice i)
//   req_ready                   : per-requester grant from the arbiter
//   clr_start/clr_busy/clr_done : bulk-clear request and status
//   wr_en/wr_addr/wr_data       : registered write port toward the register file
// Modports: master = requester/register-file side, slave = arbiter.
interface regfile_wr_arbiter_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 3
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          clr_start;
  logic                          clr_busy;
  logic                          clr_done;
  logic                          wr_en;
  logic [ADDR_WIDTH-1:0]         wr_addr;
  logic [DATA_WIDTH-1:0]         wr_data;

  modport master (
    output req_valid, req_addr, req_data, clr_start,
    input  req_ready, clr_busy, clr_done, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  req_valid, req_addr, req_data, clr_start,
    output req_ready, clr_busy, clr_done, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin write arbiter for a register file with optional bulk clear.
//   clk : single clock, all state on rising edge
//   rst : synchronous active-high reset
//   bus : regfile_wr_arbiter_if.slave (requests, grants, clear control, write port)
// Grants are combinational (one-hot or zero) from a rotating priority pointer;
// a transfer appears on the registered write port one cycle later.
// Optional feature macro: REGFILE_WR_ARBITER_CLEAR_EN enables the CLEAR state,
// which writes zero to every entry 0..REG_COUNT-1 and then pulses clr_done.
module regfile_wr_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 16,
  parameter int REG_COUNT  = 32,
  parameter int NUM_REQ    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_wr_arbiter_if.slave   bus
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]         r_ptr;
  logic [PW-1:0]         w_ptr_nxt;
  logic [NUM_REQ-1:0]    w_grant;
  logic                  w_found;
  logic                  w_arb_en;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;

`ifdef REGFILE_WR_ARBITER_CLEAR_EN
  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_clr_done;
  logic                  w_clr_last;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr_last  = (r_cnt == ADDR_WIDTH'(REG_COUNT - 1));
    case (r_state)
      ST_IDLE:  if (bus.clr_start) w_state_nxt = ST_CLEAR;
      ST_CLEAR: if (w_clr_last)    w_state_nxt = ST_IDLE;
    endcase
  end

  // A clear request wins over every requester in the cycle it is seen.
  assign w_arb_en     = !rst && (r_state == ST_IDLE) && !bus.clr_start;
  assign bus.clr_busy = (r_state == ST_CLEAR);
  assign bus.clr_done = r_clr_done;
`else
  logic w_unused_clr;
  assign w_unused_clr = bus.clr_start;
  assign w_arb_en     = !rst;
  assign bus.clr_busy = 1'b0;
  assign bus.clr_done = 1'b0;
`endif

  // Rotating-priority search: offset k from the pointer picks candidate j;
  // the first valid candidate wins. Constant j keeps all slices static.
  always_comb begin
    w_grant    = '0;
    w_found    = 1'b0;
    w_sel_addr = '0;
    w_sel_data = '0;
    w_ptr_nxt  = r_ptr;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!w_found && w_arb_en && bus.req_valid[j] &&
            ((32'(r_ptr) + k) % unsigned'(NUM_REQ)) == j) begin
          w_found    = 1'b1;
          w_grant[j] = 1'b1;
          w_sel_addr = bus.req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
          w_sel_data = bus.req_data[j*DATA_WIDTH +: DATA_WIDTH];
          w_ptr_nxt  = (j == unsigned'(NUM_REQ - 1)) ? '0 : PW'(j + 1);
        end
      end
    end
  end

  assign bus.req_ready = w_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
`ifdef REGFILE_WR_ARBITER_CLEAR_EN
      r_cnt      <= '0;
      r_clr_done <= 1'b0;
`endif
    end else begin
`ifdef REGFILE_WR_ARBITER_CLEAR_EN
      r_clr_done <= 1'b0;
      if (r_state == ST_CLEAR) begin
        // Counter doubles as the clear address and parks at REG_COUNT-1.
        if (w_clr_last) begin
          r_wr_en    <= 1'b0;
          r_clr_done <= 1'b1;
        end else begin
          r_wr_en   <= 1'b1;
          r_cnt     <= r_cnt + 1'b1;
          r_wr_addr <= r_cnt + 1'b1;
          r_wr_data <= '0;
        end
      end else if (bus.clr_start) begin
        r_cnt     <= '0;
        r_wr_en   <= 1'b1;
        r_wr_addr <= '0;
        r_wr_data <= '0;
      end else
`endif
      if (w_found) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= w_sel_addr;
        r_wr_data <= w_sel_data;
        r_ptr     <= w_ptr_nxt;
      end else begin
        r_wr_en <= 1'b0;
      end
    end
  end

  assign bus.wr_en   = r_wr_en;
  assign bus.wr_addr = r_wr_addr;
  assign bus.wr_data = r_wr_data;

endmodule
